mem_ctrler: RTL and testbench

//  Sole owner of the byte-wide RAM/IO port. Serves cache-line refill and write-back bursts for the LS buffer's data cache
//  and the inst fetcher's i-cache, plus single-byte IO accesses (addr >= IO_THRESHOLD) from the LS buffer. Each request
//  is serialised into RAM byte cycles. Completion is signalled by a one-cycle ready pulse on the requesting port.

---
 rtl/mem_ctrler.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_ctrler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrler.sv
// mem_ctrler: single owner of the byte-wide RAM/IO port.
// Serialises cache-line bursts and IO byte accesses.
module mem_ctrler #(
  parameter int LINE_WIDTH_LOG2 = 4,
  parameter int ADDR_W          = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rdy,
  input  logic                                  reset_from_rob_bus,
  input  logic                                  if_valid,
  input  logic [ADDR_W-1:0]                     if_addr,
  output logic                                  if_ready,
  output logic [8*(1<<LINE_WIDTH_LOG2)-1:0]     if_line,
  input  logic                                  ls_valid,
  input  logic                                  ls_rw_flag,
  input  logic [ADDR_W-1:0]                     ls_addr,
  input  logic [8*(1<<LINE_WIDTH_LOG2)-1:0]     ls_line_in,
  output logic                                  ls_ready,
  output logic [8*(1<<LINE_WIDTH_LOG2)-1:0]     ls_line_out,
  input  logic                                  io_valid,
  input  logic                                  io_rw_flag,
  input  logic [ADDR_W-1:0]                     io_addr,
  input  logic [7:0]                            io_byte_in,
  output logic                                  io_ready,
  output logic [7:0]                            io_byte_out,
  input  logic                                  io_buffer_full,
  input  logic [7:0]                            mem_din,
  output logic [7:0]                            mem_dout,
  output logic [ADDR_W-1:0]                     mem_a,
  output logic                                  mem_wr
);

  localparam int LW = LINE_WIDTH_LOG2;
  localparam int LB = 1 << LW;
  localparam int CW = LW + 1;
  localparam int LV = 8 * LB;
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(LB - 1);

  typedef enum logic [2:0] {
    IDLE, LINE_RD, LINE_WR, IO_RD, IO_WR, DONE
  } state_t;

  typedef enum logic [1:0] {
    G_IF, G_LS, G_IO
  } gnt_t;

  state_t            state, state_nx;
  gnt_t              gnt, gnt_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [ADDR_W-1:0] base, base_nx;
  logic              last_data, last_nx;
  logic [LV-1:0]     lbuf, lbuf_nx;
  logic [ADDR_W-1:0] a_nx;
  logic [7:0]        dout_nx;
  logic              wr_q, wr_nx;
  logic              if_rdy_nx, ls_rdy_nx, io_rdy_nx;
  logic [LV-1:0]     if_line_nx, ls_line_nx;
  logic [7:0]        io_byte_nx;
  logic [LW-1:0]     idx_p1, idx_m1;
  logic              pick_if, g_if, g_ls, g_io;

  assign idx_p1 = cnt[LW-1:0] + 1'b1;
  assign idx_m1 = cnt[LW-1:0] - 1'b1;

  // Data requests alternate with fetch when both wait
  assign pick_if = if_valid & (~(ls_valid | io_valid) | last_data);
  assign g_if = pick_if;
  assign g_ls = ls_valid & ~pick_if;
  assign g_io = io_valid & ~ls_valid & ~pick_if;

  assign mem_wr = rdy & (wr_q | ((state == IO_WR) & ~io_buffer_full));

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    cnt_nx     = cnt;
    base_nx    = base;
    last_nx    = last_data;
    lbuf_nx    = lbuf;
    a_nx       = mem_a;
    dout_nx    = mem_dout;
    wr_nx      = wr_q;
    if_line_nx = if_line;
    ls_line_nx = ls_line_out;
    io_byte_nx = io_byte_out;
    if_rdy_nx  = if_ready & ~rdy;
    ls_rdy_nx  = ls_ready & ~rdy;
    io_rdy_nx  = io_ready & ~rdy;
    if (rdy) begin
      unique case (state)
        IDLE: begin
          if (!reset_from_rob_bus) begin
            unique case (1'b1)
              g_if: begin
                state_nx = LINE_RD;
                gnt_nx   = G_IF;
                last_nx  = 1'b0;
                base_nx  = if_addr & MASK;
                a_nx     = if_addr & MASK;
                cnt_nx   = '0;
              end
              g_ls: begin
                gnt_nx  = G_LS;
                last_nx = 1'b1;
                base_nx = ls_addr & MASK;
                a_nx    = ls_addr & MASK;
                cnt_nx  = '0;
                if (ls_rw_flag) begin
                  state_nx = LINE_WR;
                  lbuf_nx  = ls_line_in;
                  dout_nx  = ls_line_in[7:0];
                  wr_nx    = 1'b1;
                end else begin
                  state_nx = LINE_RD;
                end
              end
              g_io: begin
                gnt_nx   = G_IO;
                last_nx  = 1'b1;
                a_nx     = io_addr;
                dout_nx  = io_byte_in;
                cnt_nx   = '0;
                state_nx = io_rw_flag ? IO_WR : IO_RD;
              end
              default: ;
            endcase
          end
        end
        LINE_RD: begin
          if (reset_from_rob_bus) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
            if (cnt < CW'(LB - 1))
              a_nx = base + ADDR_W'(idx_p1);
            // Data lags the address by one cycle
            if (cnt != '0)
              lbuf_nx[{idx_m1, 3'b000} +: 8] = mem_din;
            if (cnt == CW'(LB)) begin
              state_nx = DONE;
              if (gnt == G_IF) begin
                if_rdy_nx  = 1'b1;
                if_line_nx = lbuf_nx;
              end else begin
                ls_rdy_nx  = 1'b1;
                ls_line_nx = lbuf_nx;
              end
            end
          end
        end
        LINE_WR: begin
          if (cnt == CW'(LB - 1)) begin
            wr_nx     = 1'b0;
            ls_rdy_nx = 1'b1;
            state_nx  = DONE;
          end else begin
            cnt_nx  = cnt + 1'b1;
            a_nx    = base + ADDR_W'(idx_p1);
            dout_nx = lbuf[{idx_p1, 3'b000} +: 8];
          end
        end
        IO_RD: begin
          if (reset_from_rob_bus) begin
            state_nx = IDLE;
          end else if (cnt == '0) begin
            cnt_nx = CW'(1);
          end else begin
            io_byte_nx = mem_din;
            io_rdy_nx  = 1'b1;
            state_nx   = DONE;
          end
        end
        IO_WR: begin
          if (!io_buffer_full) begin
            io_rdy_nx = 1'b1;
            state_nx  = DONE;
          end
        end
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= G_IF;
      cnt         <= '0;
      base        <= '0;
      last_data   <= 1'b0;
      lbuf        <= '0;
      mem_a       <= '0;
      mem_dout    <= '0;
      wr_q        <= 1'b0;
      if_ready    <= 1'b0;
      ls_ready    <= 1'b0;
      io_ready    <= 1'b0;
      if_line     <= '0;
      ls_line_out <= '0;
      io_byte_out <= '0;
    end else begin
      state       <= state_nx;
      gnt         <= gnt_nx;
      cnt         <= cnt_nx;
      base        <= base_nx;
      last_data   <= last_nx;
      lbuf        <= lbuf_nx;
      mem_a       <= a_nx;
      mem_dout    <= dout_nx;
      wr_q        <= wr_nx;
      if_ready    <= if_rdy_nx;
      ls_ready    <= ls_rdy_nx;
      io_ready    <= io_rdy_nx;
      if_line     <= if_line_nx;
      ls_line_out <= ls_line_nx;
      io_byte_out <= io_byte_nx;
    end
  end

endmodule

// File: tb/tb_mem_ctrler.sv
// tb_mem_ctrler: directed vectors plus hand sequences
// for arbitration, flush and stall behaviour.
module tb_mem_ctrler;

  localparam int K_IF  = 0;
  localparam int K_LSR = 1;
  localparam int K_LSW = 2;
  localparam int K_IOR = 3;
  localparam int K_IOW = 4;

  localparam logic [127:0] L100 = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] LF0  = 128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1;
  localparam logic [127:0] LAA  = {16{8'hAA}};
  localparam logic [127:0] L300 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] L400 = 128'hFEDCBA98765432100123456789ABCDEF;
  localparam logic [127:0] L500 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [127:0] data;
    int           full_n;
    int           flush_at;
    int           stall_at;
    int           stall_n;
    int           lat;
  } vec_t;

  logic         clk = 0;
  logic         rst, rdy, reset_from_rob_bus;
  logic         if_valid, if_ready;
  logic [31:0]  if_addr;
  logic [127:0] if_line;
  logic         ls_valid, ls_rw_flag, ls_ready;
  logic [31:0]  ls_addr;
  logic [127:0] ls_line_in, ls_line_out;
  logic         io_valid, io_rw_flag, io_ready, io_buffer_full;
  logic [31:0]  io_addr;
  logic [7:0]   io_byte_in, io_byte_out;
  logic [7:0]   mem_din = 8'h00;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;

  logic [7:0] ram [0:65535];
  int ntest = 0;
  int nfail = 0;
  int ifc = 0, lsc = 0, ioc = 0, dbl = 0;
  logic if_p = 0, ls_p = 0, io_p = 0;
  vec_t vt [17];

  mem_ctrler dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .reset_from_rob_bus(reset_from_rob_bus),
    .if_valid(if_valid), .if_addr(if_addr),
    .if_ready(if_ready), .if_line(if_line),
    .ls_valid(ls_valid), .ls_rw_flag(ls_rw_flag),
    .ls_addr(ls_addr), .ls_line_in(ls_line_in),
    .ls_ready(ls_ready), .ls_line_out(ls_line_out),
    .io_valid(io_valid), .io_rw_flag(io_rw_flag),
    .io_addr(io_addr), .io_byte_in(io_byte_in),
    .io_ready(io_ready), .io_byte_out(io_byte_out),
    .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // RAM shares the chip enable with the controller
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
      mem_din <= ram[mem_a[15:0]];
    end
  end

  always @(negedge clk) begin
    if (if_ready) ifc++;
    if (ls_ready) lsc++;
    if (io_ready) ioc++;
    if ((if_ready && if_p) || (ls_ready && ls_p) || (io_ready && io_p))
      dbl++;
    if_p = if_ready;
    ls_p = ls_ready;
    io_p = io_ready;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input string nm);
    logic [31:0] base;
    logic [31:0] afrz;
    logic        got;
    int cyc, nwr, badwr, badst, i0, l0, o0, ewr;
    base = {v.addr[31:4], 4'h0};
    afrz = '0;
    i0 = ifc; l0 = lsc; o0 = ioc;
    io_buffer_full = (v.full_n > 0);
    case (v.kind)
      K_IF:  begin if_addr = v.addr; if_valid = 1; end
      K_LSR: begin ls_addr = v.addr; ls_rw_flag = 0; ls_valid = 1; end
      K_LSW: begin
        ls_addr = v.addr; ls_rw_flag = 1;
        ls_line_in = v.data; ls_valid = 1;
      end
      K_IOR: begin io_addr = v.addr; io_rw_flag = 0; io_valid = 1; end
      default: begin
        io_addr = v.addr; io_rw_flag = 1;
        io_byte_in = v.data[7:0]; io_valid = 1;
      end
    endcase
    got = 0; cyc = 0; nwr = 0; badwr = 0; badst = 0;
    while (!got && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == v.full_n + 1) io_buffer_full = 0;
      reset_from_rob_bus = (cyc == v.flush_at);
      if (v.stall_n > 0 && cyc == v.stall_at) rdy = 0;
      if (v.stall_n > 0 && cyc == v.stall_at + v.stall_n) rdy = 1;
      #1;
      if (!rdy) begin
        if (cyc == v.stall_at) afrz = mem_a;
        if (mem_wr || mem_a !== afrz) badst++;
      end
      if (mem_wr) begin
        if (io_buffer_full) badwr++;
        if (v.kind == K_LSW) begin
          if (nwr > 15 || mem_a !== base + 32'(nwr) ||
              mem_dout !== v.data[8*nwr +: 8]) badwr++;
        end else if (mem_a !== v.addr || mem_dout !== v.data[7:0]) begin
          badwr++;
        end
        nwr++;
      end
      case (v.kind)
        K_IF:          got = if_ready;
        K_LSR, K_LSW:  got = ls_ready;
        default:       got = io_ready;
      endcase
    end
    if_valid = 0; ls_valid = 0; io_valid = 0;
    reset_from_rob_bus = 0; io_buffer_full = 0; rdy = 1;
    chk({nm, "_lat"}, 128'(cyc - 1), 128'(v.lat));
    case (v.kind)
      K_IF:  chk({nm, "_line"}, if_line, v.data);
      K_LSR: chk({nm, "_line"}, ls_line_out, v.data);
      K_IOR: chk({nm, "_byte"}, {120'b0, io_byte_out}, v.data);
      default: ;
    endcase
    ewr = (v.kind == K_LSW) ? 16 : (v.kind == K_IOW) ? 1 : 0;
    chk({nm, "_nwr"}, 128'(nwr), 128'(ewr));
    chk({nm, "_wrseq"}, 128'(badwr), 128'd0);
    if (v.stall_n > 0) chk({nm, "_stall"}, 128'(badst), 128'd0);
    @(posedge clk);
    #2;
    chk({nm, "_pulses"},
        {116'b0, 4'(ifc - i0), 4'(lsc - l0), 4'(ioc - o0)},
        {116'b0, 4'(v.kind == K_IF),
         4'(v.kind == K_LSR || v.kind == K_LSW),
         4'(v.kind == K_IOR || v.kind == K_IOW)});
  endtask

  task automatic arb(input bit if_first, input string nm);
    int cyc, t_if, t_ls;
    if_addr = 32'h100; ls_addr = 32'h1F0; ls_rw_flag = 0;
    if_valid = 1; ls_valid = 1;
    t_if = -1; t_ls = -1; cyc = 0;
    while ((t_if < 0 || t_ls < 0) && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
      if (if_ready && t_if < 0) begin t_if = cyc - 1; if_valid = 0; end
      if (ls_ready && t_ls < 0) begin t_ls = cyc - 1; ls_valid = 0; end
    end
    if_valid = 0; ls_valid = 0;
    chk({nm, "_if_lat"}, 128'(t_if), if_first ? 128'd17 : 128'd36);
    chk({nm, "_ls_lat"}, 128'(t_ls), if_first ? 128'd36 : 128'd17);
    chk({nm, "_if_line"}, if_line, L100);
    chk({nm, "_ls_line"}, ls_line_out, LF0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int cyc, i0;
    vec_t hv;
    for (int k = 0; k < 65536; k++) ram[k] = 8'(k + 1);
    vt[0]  = '{K_LSR, 32'h0000_0104, L100,      0, 0, 0, 0, 17};
    vt[1]  = '{K_LSW, 32'h0000_0200, LAA,       0, 0, 0, 0, 16};
    vt[2]  = '{K_IF,  32'h0000_020C, LAA,       0, 0, 0, 0, 17};
    vt[3]  = '{K_LSW, 32'h0000_030F, L300,      0, 0, 0, 0, 16};
    vt[4]  = '{K_IF,  32'h0000_0300, L300,      0, 0, 0, 0, 17};
    vt[5]  = '{K_LSR, 32'hFFFF_FFF5, LF0,       0, 0, 0, 0, 17};
    vt[6]  = '{K_IF,  32'h0000_01F0, LF0,       0, 0, 0, 0, 17};
    vt[7]  = '{K_IOW, 32'h0003_0004, 128'h41,   5, 0, 0, 0, 6};
    vt[8]  = '{K_IOR, 32'h0003_0004, 128'h41,   0, 0, 0, 0, 2};
    vt[9]  = '{K_IOR, 32'h0003_0013, 128'h14,   0, 0, 0, 0, 2};
    vt[10] = '{K_IOW, 32'h0003_0020, 128'h5A,   0, 0, 0, 0, 1};
    vt[11] = '{K_LSR, 32'h0000_0200, LAA,       0, 0, 0, 0, 17};
    vt[12] = '{K_LSR, 32'h0000_0104, L100,      0, 0, 6, 3, 20};
    vt[13] = '{K_LSW, 32'h0000_0400, L400,      0, 6, 0, 0, 16};
    vt[14] = '{K_LSR, 32'h0000_0400, L400,      0, 0, 0, 0, 17};
    vt[15] = '{K_LSW, 32'h0000_0500, L500,      0, 0, 4, 2, 18};
    vt[16] = '{K_IF,  32'h0000_0500, L500,      0, 0, 0, 0, 17};

    rst = 1; rdy = 0; reset_from_rob_bus = 0;
    if_valid = 0; if_addr = '0;
    ls_valid = 0; ls_rw_flag = 0; ls_addr = '0; ls_line_in = '0;
    io_valid = 0; io_rw_flag = 0; io_addr = '0; io_byte_in = '0;
    io_buffer_full = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {124'b0, if_ready, ls_ready, io_ready, mem_wr}, 128'd0);
    chk("rst_addr", {96'b0, mem_a}, 128'd0);
    rdy = 1;
    @(posedge clk);
    #1;
    chk("rst_lines", if_line | ls_line_out, 128'd0);
    chk("rst_bytes", {112'b0, mem_dout, io_byte_out}, 128'd0);
    rst = 0;
    @(posedge clk);
    #2;

    for (int i = 0; i < 17; i++) run_req(vt[i], $sformatf("v%0d", i));

    arb(1'b0, "arb_lsfirst");
    hv = '{K_IOR, 32'h0003_0013, 128'h14, 0, 0, 0, 0, 2};
    run_req(hv, "arb_io");
    arb(1'b1, "arb_iffirst");

    i0 = ifc;
    if_addr = 32'h200; if_valid = 1;
    for (cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      #2;
      if (cyc == 6) begin
        reset_from_rob_bus = 1;
        if_valid = 0;
      end else begin
        reset_from_rob_bus = 0;
      end
    end
    chk("flush_pulses", 128'(ifc - i0), 128'd0);
    chk("flush_line", if_line, L100);
    hv = '{K_IF, 32'h0000_0200, LAA, 0, 0, 0, 0, 17};
    run_req(hv, "after_flush");

    chk("single_pulse", 128'(dbl), 128'd0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
